// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - two-requester round-robin front end for a single I2C controller
// One transaction outstanding at a time; a saturating watchdog bounds each controller phase.
module i2c_arbiter #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 7,
  parameter int TIMEOUT   = 2_000_000
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ0_VALID,
  input  logic [ADDR_BITS-1:0] REQ0_ADDR,
  input  logic                 REQ0_RW,
  input  logic [DATA_BITS-1:0] REQ0_DATA,
  output logic                 REQ0_READY,
  input  logic                 REQ1_VALID,
  input  logic [ADDR_BITS-1:0] REQ1_ADDR,
  input  logic                 REQ1_RW,
  input  logic [DATA_BITS-1:0] REQ1_DATA,
  output logic                 REQ1_READY,
  output logic                 RSP0_VALID,
  output logic [DATA_BITS-1:0] RSP0_DATA,
  output logic                 RSP0_ERR,
  output logic                 RSP1_VALID,
  output logic [DATA_BITS-1:0] RSP1_DATA,
  output logic                 RSP1_ERR,
  output logic [ADDR_BITS-1:0] C_IADDR,
  output logic [DATA_BITS-1:0] C_IDATA,
  output logic                 C_I_RW,
  output logic                 C_IDRDY,
  input  logic                 C_BUSY,
  input  logic                 C_ODRDY,
  input  logic [DATA_BITS-1:0] C_ODATA
);

  localparam int WD_BITS = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    RESPOND
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [WD_BITS-1:0]   wdog;
  logic [WD_BITS-1:0]   wdog_inc;
  logic                 wd_expired;
  logic                 last_grant;
  logic                 grant_id;
  logic                 grant_sel;
  logic                 grant_fire;
  logic                 done_evt;
  logic [ADDR_BITS-1:0] cmd_addr;
  logic [DATA_BITS-1:0] cmd_data;
  logic                 cmd_rw;
  logic [DATA_BITS-1:0] rsp_data;
  logic                 rsp_err;

  // Round-robin: on a tie the requester not served last wins.
  always_comb begin
    grant_sel = 1'b0;
    if (REQ0_VALID && REQ1_VALID) begin
      grant_sel = ~last_grant;
    end else if (REQ1_VALID) begin
      grant_sel = 1'b1;
    end
    grant_fire = (state == IDLE) && !C_BUSY && (REQ0_VALID || REQ1_VALID);
  end

  always_comb begin
    wdog_inc   = (wdog == WD_BITS'(TIMEOUT)) ? wdog : wdog + WD_BITS'(1);
    wd_expired = (wdog >= WD_BITS'(TIMEOUT - 1));
    done_evt   = 1'b0;
    if (state == WAIT_START) begin
      done_evt = C_BUSY;
    end else if (state == WAIT_DONE) begin
      done_evt = cmd_rw ? C_ODRDY : !C_BUSY;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (grant_fire) state_nxt = ISSUE;
      ISSUE:      state_nxt = WAIT_START;
      WAIT_START: begin
        if (done_evt) begin
          state_nxt = WAIT_DONE;
        end else if (wd_expired) begin
          state_nxt = RESPOND;
        end
      end
      WAIT_DONE:  if (done_evt || wd_expired) state_nxt = RESPOND;
      RESPOND:    state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Command, grant and response registers; completion outranks a same-cycle watchdog expiry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wdog       <= '0;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      cmd_addr   <= '0;
      cmd_data   <= '0;
      cmd_rw     <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_fire) begin
            grant_id   <= grant_sel;
            last_grant <= grant_sel;
            cmd_addr   <= grant_sel ? REQ1_ADDR : REQ0_ADDR;
            cmd_data   <= grant_sel ? REQ1_DATA : REQ0_DATA;
            cmd_rw     <= grant_sel ? REQ1_RW : REQ0_RW;
          end
        end
        ISSUE: begin
          wdog     <= '0;
          rsp_data <= '0;
          rsp_err  <= 1'b0;
        end
        WAIT_START: begin
          if (done_evt) begin
            wdog <= '0;
          end else begin
            wdog <= wdog_inc;
            if (wd_expired) begin
              rsp_data <= '0;
              rsp_err  <= 1'b1;
            end
          end
        end
        WAIT_DONE: begin
          wdog <= wdog_inc;
          if (done_evt) begin
            rsp_data <= cmd_rw ? C_ODATA : '0;
            rsp_err  <= 1'b0;
          end else if (wd_expired) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // READY is combinational with the grant, so it is masked while reset is held.
  always_comb begin
    REQ0_READY = grant_fire && !grant_sel && !RST;
    REQ1_READY = grant_fire && grant_sel && !RST;
    C_IDRDY    = (state == ISSUE);
    RSP0_VALID = (state == RESPOND) && !grant_id;
    RSP1_VALID = (state == RESPOND) && grant_id;
    RSP0_DATA  = RSP0_VALID ? rsp_data : '0;
    RSP1_DATA  = RSP1_VALID ? rsp_data : '0;
    RSP0_ERR   = RSP0_VALID && rsp_err;
    RSP1_ERR   = RSP1_VALID && rsp_err;
    C_IADDR    = cmd_addr;
    C_IDATA    = cmd_data;
    C_I_RW     = cmd_rw;
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb/tb_i2c_arbiter.sv - directed bench for i2c_arbiter with a behavioural controller model
module tb_i2c_arbiter;
  localparam int DB = 8;
  localparam int AB = 7;
  localparam int TO = 1000;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ0_VALID, REQ0_RW, REQ0_READY;
  logic [AB-1:0] REQ0_ADDR;
  logic [DB-1:0] REQ0_DATA;
  logic          REQ1_VALID, REQ1_RW, REQ1_READY;
  logic [AB-1:0] REQ1_ADDR;
  logic [DB-1:0] REQ1_DATA;
  logic          RSP0_VALID, RSP0_ERR, RSP1_VALID, RSP1_ERR;
  logic [DB-1:0] RSP0_DATA, RSP1_DATA;
  logic [AB-1:0] C_IADDR;
  logic [DB-1:0] C_IDATA, C_ODATA;
  logic          C_I_RW, C_IDRDY, C_BUSY, C_ODRDY;

  logic          mdl_busy = 1'b0, mdl_odrdy = 1'b0, mdl_rd = 1'b0;
  logic          mdl_on = 1'b1, ext_busy = 1'b0;
  logic [DB-1:0] mdl_rdata = '0;
  int            mcnt = -1;
  int            checks = 0, failures = 0;
  int            wr;

  assign C_BUSY  = mdl_busy | ext_busy;
  assign C_ODRDY = mdl_odrdy;
  assign C_ODATA = mdl_odrdy ? mdl_rdata : '0;

  always #5 CLK = ~CLK;

  i2c_arbiter #(.DATA_BITS(DB), .ADDR_BITS(AB), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_ADDR(REQ0_ADDR), .REQ0_RW(REQ0_RW), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_ADDR(REQ1_ADDR), .REQ1_RW(REQ1_RW), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
    .RSP0_VALID(RSP0_VALID), .RSP0_DATA(RSP0_DATA), .RSP0_ERR(RSP0_ERR),
    .RSP1_VALID(RSP1_VALID), .RSP1_DATA(RSP1_DATA), .RSP1_ERR(RSP1_ERR),
    .C_IADDR(C_IADDR), .C_IDATA(C_IDATA), .C_I_RW(C_I_RW), .C_IDRDY(C_IDRDY),
    .C_BUSY(C_BUSY), .C_ODRDY(C_ODRDY), .C_ODATA(C_ODATA)
  );

  // Controller model: busy from 3 to 52 cycles after the strobe; read data on the last busy cycle.
  always @(posedge CLK) begin
    #1;
    if (RST) begin
      mcnt = -1; mdl_busy = 1'b0; mdl_odrdy = 1'b0;
    end else begin
      if (C_IDRDY) begin
        mcnt = 0; mdl_rd = C_I_RW;
      end else if (mcnt >= 0) begin
        mcnt++;
      end
      mdl_busy  = mdl_on && mcnt >= 3 && mcnt <= 52;
      mdl_odrdy = mdl_on && mdl_rd && mcnt == 52;
      if (mcnt >= 53) mcnt = -1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {24'h0, REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID, RSP0_ERR, RSP1_ERR, C_IDRDY, C_I_RW}, 0);
    chk({tag, "_iaddr"}, {25'h0, C_IADDR}, 0);
    chk({tag, "_idata"}, {24'h0, C_IDATA}, 0);
    chk({tag, "_rspdata"}, {16'h0, RSP0_DATA, RSP1_DATA}, 0);
  endtask

  // Waits for a grant, follows the transaction to its response and checks it end to end.
  task automatic run(input string tag, input int eg, input logic [AB-1:0] ea, input logic [DB-1:0] ed,
                     input logic erw, input logic [DB-1:0] eq, input logic ee, input int elat,
                     input bit hold, output int wready);
    int g, r, lat, ni, nx, nu;
    logic [DB-1:0] d, cd;
    logic [AB-1:0] ca;
    logic e, cr;
    g = -1; r = -1; lat = 0; ni = 0; nx = 0; nu = 0; wready = 0;
    d = 'x; e = 1'bx; ca = 'x; cd = 'x; cr = 1'bx;
    #1;
    while (g < 0 && wready < 1100) begin
      if (REQ0_READY && REQ1_READY) g = 2;
      else if (REQ0_READY) g = 0;
      else if (REQ1_READY) g = 1;
      else begin
        @(negedge CLK); wready++;
      end
    end
    if (g >= 0) begin
      @(posedge CLK); #1;
      if (!hold) begin
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
      end
    end
    while (g >= 0 && r < 0 && lat < 1100) begin
      @(negedge CLK); lat++;
      if (C_IDRDY) begin
        ni++;
        if (ni == 1) begin
          ca = C_IADDR; cd = C_IDATA; cr = C_I_RW;
        end
      end else if (ni > 0 && (C_IADDR !== ca || C_IDATA !== cd || C_I_RW !== cr)) begin
        nu++;
      end
      if (REQ0_READY || REQ1_READY) nx++;
      if (RSP0_VALID && RSP1_VALID) r = 2;
      else if (RSP0_VALID) begin r = 0; d = RSP0_DATA; e = RSP0_ERR; end
      else if (RSP1_VALID) begin r = 1; d = RSP1_DATA; e = RSP1_ERR; end
    end
    chk({tag, "_grant"}, g, eg);
    chk({tag, "_rsp_port"}, r, eg);
    chk({tag, "_rsp_data"}, {24'h0, d}, {24'h0, eq});
    chk({tag, "_rsp_err"}, {31'h0, e}, {31'h0, ee});
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_idrdy_pulses"}, ni, 1);
    chk({tag, "_extra_ready"}, nx, 0);
    chk({tag, "_iaddr"}, {25'h0, ca}, {25'h0, ea});
    chk({tag, "_idata"}, {24'h0, cd}, {24'h0, ed});
    chk({tag, "_irw"}, {31'h0, cr}, {31'h0, erw});
    chk({tag, "_cmd_unstable"}, nu, 0);
    @(negedge CLK);
    chk({tag, "_rsp_one_cycle"}, {30'h0, RSP0_VALID, RSP1_VALID}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    REQ0_VALID = 1'b1; REQ0_ADDR = 7'h11; REQ0_DATA = 8'h22; REQ0_RW = 1'b0;
    REQ1_VALID = 1'b1; REQ1_ADDR = 7'h33; REQ1_DATA = 8'h44; REQ1_RW = 1'b1;
    mdl_rdata = 8'h5A;
    repeat (2) @(negedge CLK);
    chk_zero("reset");

    // Both requesters valid continuously from reset release: 0,1,0,1.
    @(posedge CLK); #1; RST = 1'b0;
    run("rr0", 0, 7'h11, 8'h22, 1'b0, 8'h00, 1'b0, 55, 1'b1, wr);
    chk("rr0_first_edge_grant", wr, 0);
    run("rr1", 1, 7'h33, 8'h44, 1'b1, 8'h5A, 1'b0, 54, 1'b1, wr);
    run("rr2", 0, 7'h11, 8'h22, 1'b0, 8'h00, 1'b0, 55, 1'b1, wr);
    run("rr3", 1, 7'h33, 8'h44, 1'b1, 8'h5A, 1'b0, 54, 1'b0, wr);

    @(posedge CLK); #1;
    REQ0_VALID = 1'b1; REQ0_ADDR = 7'h50; REQ0_DATA = 8'hA5; REQ0_RW = 1'b0;
    run("wr0", 0, 7'h50, 8'hA5, 1'b0, 8'h00, 1'b0, 55, 1'b0, wr);

    @(posedge CLK); #1;
    mdl_rdata = 8'h3C;
    REQ1_VALID = 1'b1; REQ1_ADDR = 7'h50; REQ1_DATA = 8'h77; REQ1_RW = 1'b1;
    run("rd1", 1, 7'h50, 8'h77, 1'b1, 8'h3C, 1'b0, 54, 1'b0, wr);

    // Silent controller: response 1000 cycles after entering WAIT_START (READY + 2 + 1000).
    @(posedge CLK); #1;
    mdl_on = 1'b0;
    REQ0_VALID = 1'b1; REQ0_ADDR = 7'h2A; REQ0_DATA = 8'h81; REQ0_RW = 1'b0;
    run("wdog", 0, 7'h2A, 8'h81, 1'b0, 8'h00, 1'b1, 1002, 1'b0, wr);
    @(posedge CLK); #1;
    mdl_on = 1'b1; mdl_rdata = 8'h96;
    REQ1_VALID = 1'b1; REQ1_ADDR = 7'h2A; REQ1_DATA = 8'h00; REQ1_RW = 1'b1;
    run("after_wdog", 1, 7'h2A, 8'h00, 1'b1, 8'h96, 1'b0, 54, 1'b0, wr);

    @(posedge CLK); #1;
    ext_busy = 1'b1;
    REQ0_VALID = 1'b1; REQ0_ADDR = 7'h50; REQ0_DATA = 8'h5C; REQ0_RW = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("busy_hold_ready", {30'h0, REQ0_READY, REQ1_READY}, 0);
    end
    @(posedge CLK); #1;
    ext_busy = 1'b0;
    run("busy_rel", 0, 7'h50, 8'h5C, 1'b0, 8'h00, 1'b0, 55, 1'b0, wr);
    chk("busy_rel_ready_cycle", wr, 0);

    // Reset while the controller is mid-transfer.
    @(posedge CLK); #1;
    REQ0_VALID = 1'b1; REQ0_ADDR = 7'h50; REQ0_DATA = 8'hEE; REQ0_RW = 1'b0;
    @(posedge CLK); #1;
    REQ0_VALID = 1'b0;
    @(negedge CLK);
    chk("mid_issue_strobe", {31'h0, C_IDRDY}, 1);
    repeat (10) @(negedge CLK);
    chk("mid_cmd_addr", {25'h0, C_IADDR}, 32'h50);
    #1; RST = 1'b1;
    REQ1_VALID = 1'b1; REQ1_ADDR = 7'h0F; REQ1_DATA = 8'h03; REQ1_RW = 1'b0;
    #1;
    chk_zero("rst_mid");
    repeat (2) @(posedge CLK);
    #1;
    chk_zero("rst_held");
    RST = 1'b0;
    run("post_rst", 1, 7'h0F, 8'h03, 1'b0, 8'h00, 1'b0, 55, 1'b0, wr);
    chk("post_rst_ready_cycle", wr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
